// File: rtl/id_stage_hz.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_hz
// Purpose  : MIPS instruction-decode stage. Holds the register file, decodes
//            the IF/ID instruction, resolves branches and jumps in ID (with
//            EX/MEM operand forwarding), detects load-use and branch hazards,
//            and owns the ID/EX pipeline register with bubble, flush, debug
//            single-step gating and a HALT drain state machine.
// Ports    : clk, i_reset (async, active low)
//            i_instruction / i_pc           - IF/ID payload
//            i_we / i_wr_addr / i_wr_data_WB - writeback port
//            i_exmem_*                       - EX/MEM forwarding source
//            i_debug_mode / i_step / i_flush - pipeline control
//            o_stall_req, o_jump*            - combinational hazard/jump outputs
//            o_* (remaining)                 - registered ID/EX fields, o_stop
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_hz #(
  parameter int NB_DATA      = 32,
  parameter int NB_ADDR      = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_instruction,
  input  logic [NB_DATA-1:0] i_pc,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data_WB,
  input  logic               i_exmem_regwrite,
  input  logic               i_exmem_memread,
  input  logic [NB_ADDR-1:0] i_exmem_rd,
  input  logic [NB_DATA-1:0] i_exmem_data,
  input  logic               i_debug_mode,
  input  logic               i_step,
  input  logic               i_flush,
  output logic               o_stall_req,
  output logic               o_jump,
  output logic [1:0]         o_jump_cases,
  output logic [NB_DATA-1:0] o_addr2jump,
  output logic [NB_ADDR-1:0] o_rs,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [4:0]         o_shamt,
  output logic [5:0]         o_opcode,
  output logic [5:0]         o_func,
  output logic [NB_DATA-1:0] o_reg_DA,
  output logic [NB_DATA-1:0] o_reg_DB,
  output logic [NB_DATA-1:0] o_immediate,
  output logic [NB_DATA-1:0] o_pc,
  output logic               o_branch,
  output logic               o_regDst,
  output logic               o_mem2Reg,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_immediate_flag,
  output logic               o_sign_flag,
  output logic               o_regWrite,
  output logic [1:0]         o_aluSrc,
  output logic [1:0]         o_width,
  output logic [1:0]         o_aluOp,
  output logic               o_stop
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  localparam logic [1:0] JC_NONE   = 2'b00;
  localparam logic [1:0] JC_BRANCH = 2'b01;
  localparam logic [1:0] JC_LINK   = 2'b10;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] drain_cnt, cnt_next;

  // --------------------------------------------------------------------------
  // Instruction fields and classification
  // --------------------------------------------------------------------------
  logic [5:0]         opcode, func;
  logic [4:0]         shamt;
  logic [15:0]        imm16;
  logic [NB_ADDR-1:0] rs, rt, rd;

  assign opcode = i_instruction[31:26];
  assign func   = i_instruction[5:0];
  assign shamt  = i_instruction[10:6];
  assign imm16  = i_instruction[15:0];
  assign rs     = NB_ADDR'(i_instruction[25:21]);
  assign rt     = NB_ADDR'(i_instruction[20:16]);
  assign rd     = NB_ADDR'(i_instruction[15:11]);

  logic is_rtype, is_jr, is_jalr, is_shift, is_j, is_jal, is_beq, is_bne;
  logic is_load, is_store, is_alui, is_halt, is_cmp, uses_rt;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (func == FN_JR);
  assign is_jalr  = is_rtype && (func == FN_JALR);
  assign is_shift = is_rtype && ((func == FN_SLL) || (func == FN_SRL) || (func == FN_SRA));
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_load  = (opcode[5:3] == 3'b100);
  assign is_store = (opcode[5:3] == 3'b101);
  assign is_alui  = (opcode[5:3] == 3'b001);
  assign is_halt  = &i_instruction;
  // Instructions whose operands are compared/consumed in ID itself.
  assign is_cmp   = is_beq || is_bne || is_jr || is_jalr;
  assign uses_rt  = is_rtype || is_beq || is_bne || is_store;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic       d_regDst, d_regWrite, d_branch, d_sign_flag;
  logic [1:0] d_aluSrc, d_width, d_aluOp;
  logic [NB_DATA-1:0] imm_sext, imm_zext, d_immediate;

  assign d_regDst    = is_rtype;
  assign d_regWrite  = (is_rtype && !is_jr) || is_load || is_alui || is_jal;
  assign d_branch    = is_beq || is_bne;
  // Signed loads/stores and ADDI/ADDIU/SLTI/SLTIU all have opcode bit 2 clear.
  assign d_sign_flag = (is_load || is_store || is_alui) && !opcode[2];
  assign d_aluSrc    = is_shift ? 2'b10 : ((is_load || is_store || is_alui) ? 2'b01 : 2'b00);
  assign d_width     = (is_load || is_store) ? opcode[1:0] : 2'b00;
  assign d_aluOp     = is_rtype ? 2'b10 : (is_alui ? 2'b11 : (d_branch ? 2'b01 : 2'b00));

  assign imm_sext    = {{(NB_DATA-16){imm16[15]}}, imm16};
  assign imm_zext    = {{(NB_DATA-16){1'b0}}, imm16};
  // ANDI/ORI/XORI/LUI take a zero-extended immediate.
  assign d_immediate = (is_alui && opcode[2]) ? imm_zext : imm_sext;

  // --------------------------------------------------------------------------
  // Register file with write-first bypass; register 0 is hard zero.
  // --------------------------------------------------------------------------
  logic [NB_DATA-1:0] regs [2**NB_ADDR];

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < 2**NB_ADDR; k++) regs[k] <= '0;
    end else if (i_we && (i_wr_addr != '0)) begin
      regs[i_wr_addr] <= i_wr_data_WB;
    end
  end

  logic [NB_DATA-1:0] rf_a, rf_b, cmp_a, cmp_b;

  assign rf_a = (rs == '0) ? '0 :
                (i_we && (i_wr_addr == rs)) ? i_wr_data_WB : regs[rs];
  assign rf_b = (rt == '0) ? '0 :
                (i_we && (i_wr_addr == rt)) ? i_wr_data_WB : regs[rt];

  // Branch/jump-register operands: EX/MEM result outranks the WB bypass.
  assign cmp_a = (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == rs)) ? i_exmem_data : rf_a;
  assign cmp_b = (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == rt)) ? i_exmem_data : rf_b;

  // --------------------------------------------------------------------------
  // Hazard detection against the current ID/EX entry and EX/MEM
  // --------------------------------------------------------------------------
  logic [NB_ADDR-1:0] idex_dst;
  logic haz_load_use, haz_branch_ex, haz_branch_mem;

  assign idex_dst = o_regDst ? o_rd : o_rt;

  assign haz_load_use   = o_memRead && (o_rt != '0) &&
                          ((o_rt == rs) || (uses_rt && (o_rt == rt)));
  assign haz_branch_ex  = is_cmp && o_regWrite && (idex_dst != '0) &&
                          ((idex_dst == rs) || (d_branch && (idex_dst == rt)));
  assign haz_branch_mem = is_cmp && i_exmem_memread && (i_exmem_rd != '0) &&
                          ((i_exmem_rd == rs) || (d_branch && (i_exmem_rd == rt)));

  assign o_stall_req = (state == ST_RUN) && (haz_load_use || haz_branch_ex || haz_branch_mem);

  // --------------------------------------------------------------------------
  // Jump resolution
  // --------------------------------------------------------------------------
  logic [NB_DATA-1:0] j_target, b_target;
  logic               branch_taken;

  assign j_target = {i_pc[NB_DATA-1:NB_DATA-4], {(NB_DATA-4){1'b0}}} |
                    NB_DATA'({i_instruction[25:0], 2'b00});
  assign b_target = i_pc + NB_DATA'(4) + (imm_sext << 2);
  assign branch_taken = (is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b));

  always_comb begin
    o_jump       = 1'b0;
    o_jump_cases = JC_NONE;
    o_addr2jump  = '0;
    if (is_j || is_jal) begin
      o_jump       = 1'b1;
      o_jump_cases = is_jal ? JC_LINK : JC_NONE;
      o_addr2jump  = j_target;
    end else if (is_jr || is_jalr) begin
      o_jump       = 1'b1;
      o_jump_cases = is_jalr ? JC_LINK : JC_NONE;
      o_addr2jump  = cmp_a;
    end else if (branch_taken) begin
      o_jump       = 1'b1;
      o_jump_cases = JC_BRANCH;
      o_addr2jump  = b_target;
    end
    // A stalled instruction may be using stale operands; never redirect.
    if (o_stall_req) begin
      o_jump       = 1'b0;
      o_jump_cases = JC_NONE;
      o_addr2jump  = '0;
    end
  end

  // --------------------------------------------------------------------------
  // HALT drain FSM
  // --------------------------------------------------------------------------
  logic advance;
  assign advance = !i_debug_mode || i_step;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      o_stop    <= 1'b0;
    end else begin
      state     <= state_next;
      drain_cnt <= cnt_next;
      o_stop    <= (state_next == ST_HALTED);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = drain_cnt;
    if (advance) begin
      case (state)
        ST_RUN: begin
          if (is_halt && !o_stall_req) begin
            state_next = ST_DRAIN;
            cnt_next   = DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) state_next = ST_HALTED;
          else                 cnt_next   = drain_cnt - 4'd1;
        end
        ST_HALTED: state_next = ST_HALTED;
        default:   state_next = ST_RUN;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  logic load;
  assign load = !(i_flush || o_stall_req || (state != ST_RUN) || is_halt);

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      o_rs <= '0; o_rt <= '0; o_rd <= '0; o_shamt <= '0;
      o_opcode <= '0; o_func <= '0;
      o_reg_DA <= '0; o_reg_DB <= '0; o_immediate <= '0; o_pc <= '0;
      o_branch <= 1'b0; o_regDst <= 1'b0; o_mem2Reg <= 1'b0;
      o_memRead <= 1'b0; o_memWrite <= 1'b0; o_immediate_flag <= 1'b0;
      o_sign_flag <= 1'b0; o_regWrite <= 1'b0;
      o_aluSrc <= '0; o_width <= '0; o_aluOp <= '0;
    end else if (advance) begin
      o_rs             <= load ? rs          : '0;
      o_rt             <= load ? rt          : '0;
      o_rd             <= load ? rd          : '0;
      o_shamt          <= load ? shamt       : '0;
      o_opcode         <= load ? opcode      : '0;
      o_func           <= load ? func        : '0;
      o_reg_DA         <= load ? rf_a        : '0;
      o_reg_DB         <= load ? rf_b        : '0;
      o_immediate      <= load ? d_immediate : '0;
      o_pc             <= load ? i_pc        : '0;
      o_branch         <= load && d_branch;
      o_regDst         <= load && d_regDst;
      o_mem2Reg        <= load && is_load;
      o_memRead        <= load && is_load;
      o_memWrite       <= load && is_store;
      o_immediate_flag <= load && is_alui;
      o_sign_flag      <= load && d_sign_flag;
      o_regWrite       <= load && d_regWrite;
      o_aluSrc         <= load ? d_aluSrc    : '0;
      o_width          <= load ? d_width     : '0;
      o_aluOp          <= load ? d_aluOp     : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_stage_hz.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_hz
// Purpose  : Self-checking bench for id_stage_hz. A vector table drives one
//            instruction per cycle; expected ID/EX contents are queued when
//            a vector is driven and compared after the capturing edge.
//            Hand-written sequences cover HALT drain, reset mid-drain and
//            debug single-step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_hz;

  localparam int NB_DATA      = 32;
  localparam int NB_ADDR      = 5;
  localparam int DRAIN_CYCLES = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_we, i_exmem_regwrite, i_exmem_memread;
  logic        i_debug_mode, i_step, i_flush;
  logic [31:0] i_instruction, i_pc, i_wr_data_WB, i_exmem_data;
  logic [4:0]  i_wr_addr, i_exmem_rd;

  logic        o_stall_req, o_jump, o_stop;
  logic [1:0]  o_jump_cases, o_aluSrc, o_width, o_aluOp;
  logic [31:0] o_addr2jump, o_reg_DA, o_reg_DB, o_immediate, o_pc;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
  logic [5:0]  o_opcode, o_func;
  logic        o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite;
  logic        o_immediate_flag, o_sign_flag, o_regWrite;

  id_stage_hz #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .clk(clk), .i_reset(i_reset),
    .i_instruction(i_instruction), .i_pc(i_pc),
    .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data_WB(i_wr_data_WB),
    .i_exmem_regwrite(i_exmem_regwrite), .i_exmem_memread(i_exmem_memread),
    .i_exmem_rd(i_exmem_rd), .i_exmem_data(i_exmem_data),
    .i_debug_mode(i_debug_mode), .i_step(i_step), .i_flush(i_flush),
    .o_stall_req(o_stall_req), .o_jump(o_jump), .o_jump_cases(o_jump_cases),
    .o_addr2jump(o_addr2jump),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
    .o_opcode(o_opcode), .o_func(o_func),
    .o_reg_DA(o_reg_DA), .o_reg_DB(o_reg_DB), .o_immediate(o_immediate), .o_pc(o_pc),
    .o_branch(o_branch), .o_regDst(o_regDst), .o_mem2Reg(o_mem2Reg),
    .o_memRead(o_memRead), .o_memWrite(o_memWrite),
    .o_immediate_flag(o_immediate_flag), .o_sign_flag(o_sign_flag),
    .o_regWrite(o_regWrite), .o_aluSrc(o_aluSrc), .o_width(o_width), .o_aluOp(o_aluOp),
    .o_stop(o_stop)
  );

  typedef struct packed {
    logic        rw;
    logic        mr;
    logic [4:0]  rd;
    logic [31:0] da;
    logic [31:0] db;
    logic [31:0] imm;
    logic        stop;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        xrw;
    logic [4:0]  xrd;
    logic [31:0] xd;
    logic        xmr;
    logic        fl;
    logic        stall;
    logic        jump;
    logic [1:0]  jc;
    logic [31:0] ja;
    exp_t        e;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];
  exp_t sb_q [$];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] j_ins(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  function automatic exp_t mke(input int rw, input int mr, input int rd,
                               input logic [31:0] da, input logic [31:0] db,
                               input logic [31:0] imm, input int stop);
    exp_t e;
    e.rw = 1'(rw); e.mr = 1'(mr); e.rd = 5'(rd);
    e.da = da; e.db = db; e.imm = imm; e.stop = 1'(stop);
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] instr, input logic [31:0] pc,
                               input int we, input int wa, input logic [31:0] wd,
                               input int xrw, input int xrd, input logic [31:0] xd,
                               input int xmr, input int fl,
                               input int st, input int jp, input int jc,
                               input logic [31:0] ja, input exp_t e);
    vec_t v;
    v.instr = instr; v.pc = pc;
    v.we = 1'(we); v.wa = 5'(wa); v.wd = wd;
    v.xrw = 1'(xrw); v.xrd = 5'(xrd); v.xd = xd; v.xmr = 1'(xmr);
    v.fl = 1'(fl); v.stall = 1'(st); v.jump = 1'(jp); v.jc = 2'(jc);
    v.ja = ja; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_instruction = '0; i_pc = '0;
    i_we = 1'b0; i_wr_addr = '0; i_wr_data_WB = '0;
    i_exmem_regwrite = 1'b0; i_exmem_memread = 1'b0; i_exmem_rd = '0; i_exmem_data = '0;
    i_flush = 1'b0; i_step = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("%s.regWrite", tag), 32'(o_regWrite), 32'(e.rw));
      chk($sformatf("%s.memRead", tag), 32'(o_memRead), 32'(e.mr));
      chk($sformatf("%s.rd", tag), 32'(o_rd), 32'(e.rd));
      chk($sformatf("%s.reg_DA", tag), o_reg_DA, e.da);
      chk($sformatf("%s.reg_DB", tag), o_reg_DB, e.db);
      chk($sformatf("%s.immediate", tag), o_immediate, e.imm);
      chk($sformatf("%s.stop", tag), 32'(o_stop), 32'(e.stop));
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply_vec(input vec_t v, input string tag);
    i_instruction = v.instr; i_pc = v.pc;
    i_we = v.we; i_wr_addr = v.wa; i_wr_data_WB = v.wd;
    i_exmem_regwrite = v.xrw; i_exmem_rd = v.xrd; i_exmem_data = v.xd;
    i_exmem_memread = v.xmr; i_flush = v.fl;
    #1;
    chk($sformatf("%s.stall", tag), 32'(o_stall_req), 32'(v.stall));
    chk($sformatf("%s.jump", tag), 32'(o_jump), 32'(v.jump));
    chk($sformatf("%s.jump_cases", tag), 32'(o_jump_cases), 32'(v.jc));
    chk($sformatf("%s.addr2jump", tag), o_addr2jump, v.ja);
    sb_q.push_back(v.e);
    @(posedge clk); #1;
    pop_check(tag);
    @(negedge clk);
  endtask

  // One cycle with a given instruction and otherwise idle inputs.
  task automatic cycle(input logic [31:0] instr, input exp_t e, input string tag);
    idle_inputs();
    i_instruction = instr;
    sb_q.push_back(e);
    @(posedge clk); #1;
    pop_check(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] ADD, LW, ADD2, BEQ, BNE, JAL, ADDI12, JR12, ORI, BEQ9, ADD10, ADDI11, LW4, HALT;
    exp_t BUB;

    ADD    = r_ins(3, 3, 4, 0, 32);
    LW     = i_ins(35, 1, 2, 16'h0008);
    ADD2   = r_ins(2, 1, 5, 0, 32);
    BEQ    = i_ins(4, 6, 7, 16'h0003);
    BNE    = i_ins(5, 6, 7, 16'hFFFF);
    JAL    = j_ins(3, 'h100);
    ADDI12 = i_ins(8, 0, 12, 16'h0005);
    JR12   = r_ins(12, 0, 0, 0, 8);
    ORI    = i_ins(13, 1, 8, 16'h8000);
    BEQ9   = i_ins(4, 9, 0, 16'h0001);
    ADD10  = r_ins(0, 0, 10, 0, 32);
    ADDI11 = i_ins(8, 0, 11, 16'h0007);
    LW4    = i_ins(35, 1, 2, 16'h0004);
    HALT   = 32'hFFFF_FFFF;
    BUB    = mke(0, 0, 0, 0, 0, 0, 0);

    //           instr   pc            we wa wd            xrw xrd xd  xmr fl  st jp jc ja
    vt[0]  = mkv(ADD,    0,            1, 3, 32'h10,       0, 0, 0,  0, 0,  0, 0, 0, 0,
                 mke(1, 0, 4, 32'h10, 32'h10, 32'h2020, 0));
    vt[1]  = mkv(LW,     4,            1, 1, 32'h5,        0, 0, 0,  0, 0,  0, 0, 0, 0,
                 mke(1, 1, 0, 32'h5, 0, 32'h8, 0));
    vt[2]  = mkv(ADD2,   8,            1, 6, 32'h9,        0, 0, 0,  0, 0,  1, 0, 0, 0, BUB);
    vt[3]  = mkv(ADD2,   8,            1, 7, 32'h7,        0, 0, 0,  0, 0,  0, 0, 0, 0,
                 mke(1, 0, 5, 0, 32'h5, 32'h2820, 0));
    vt[4]  = mkv(BEQ,    32'h40,       0, 0, 0,            1, 6, 32'h7, 0, 0, 0, 1, 1, 32'h50,
                 mke(0, 0, 0, 32'h9, 32'h7, 32'h3, 0));
    vt[5]  = mkv(BNE,    32'h100,      0, 0, 0,            0, 0, 0,  0, 0,  0, 1, 1, 32'h100,
                 mke(0, 0, 31, 32'h9, 32'h7, 32'hFFFF_FFFF, 0));
    vt[6]  = mkv(JAL,    32'h8000_0004, 0, 0, 0,           0, 0, 0,  0, 0,  0, 1, 2, 32'h8000_0400,
                 mke(1, 0, 0, 0, 0, 32'h100, 0));
    vt[7]  = mkv(ADDI12, 32'h0,        0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0, 0,
                 mke(1, 0, 0, 0, 0, 32'h5, 0));
    vt[8]  = mkv(JR12,   32'h4,        0, 0, 0,            0, 0, 0,  0, 0,  1, 0, 0, 0, BUB);
    vt[9]  = mkv(JR12,   32'h4,        1, 12, 32'h1234,    0, 0, 0,  0, 0,  0, 1, 0, 32'h1234,
                 mke(0, 0, 0, 32'h1234, 0, 32'h8, 0));
    vt[10] = mkv(BEQ,    32'h40,       0, 0, 0,            0, 7, 0,  1, 0,  1, 0, 0, 0, BUB);
    vt[11] = mkv(ORI,    32'h44,       0, 0, 0,            0, 0, 0,  0, 1,  0, 0, 0, 0, BUB);
    vt[12] = mkv(ORI,    32'h44,       0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0, 0,
                 mke(1, 0, 16, 32'h5, 0, 32'h8000, 0));
    vt[13] = mkv(BEQ9,   32'h0,        1, 9, 32'h5,        1, 9, 0,  0, 0,  0, 1, 1, 32'h8,
                 mke(0, 0, 0, 32'h5, 0, 32'h1, 0));
    vt[14] = mkv(ADD10,  32'h0,        1, 0, 32'hDEAD,     0, 0, 0,  0, 0,  0, 0, 0, 0,
                 mke(1, 0, 10, 0, 0, 32'h5020, 0));

    idle_inputs();
    i_debug_mode = 1'b0;
    i_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.stop", 32'(o_stop), 0);
    chk("reset.regWrite", 32'(o_regWrite), 0);
    chk("reset.memRead", 32'(o_memRead), 0);
    chk("reset.reg_DA", o_reg_DA, 0);
    chk("reset.pc", o_pc, 0);
    chk("reset.aluOp", 32'(o_aluOp), 0);
    chk("reset.stall", 32'(o_stall_req), 0);
    @(negedge clk);
    i_reset = 1'b1;

    for (int i = 0; i < NV; i++) apply_vec(vt[i], $sformatf("v%0d", i));

    // HALT: the HALT bubble, then DRAIN_CYCLES bubbles; o_stop rises on the 3rd.
    idle_inputs();
    i_instruction = HALT;
    #1 chk("halt.stall", 32'(o_stall_req), 0);
    sb_q.push_back(BUB);
    @(posedge clk); #1; pop_check("halt.e0");
    @(negedge clk);
    cycle(ADD10, mke(0, 0, 0, 0, 0, 0, 0), "halt.e1");
    cycle(ADD10, mke(0, 0, 0, 0, 0, 0, 0), "halt.e2");
    cycle(ADD10, mke(0, 0, 0, 0, 0, 0, 1), "halt.e3");
    cycle(ADD10, mke(0, 0, 0, 0, 0, 0, 1), "halt.e4");

    i_reset = 1'b0;
    #1 chk("halted_reset.stop", 32'(o_stop), 0);
    @(negedge clk);
    i_reset = 1'b1;

    // Reset in the middle of DRAIN returns to RUN.
    cycle(HALT, BUB, "mid.e0");
    cycle(ADD10, BUB, "mid.e1");
    i_reset = 1'b0;
    #1 chk("mid_reset.stop", 32'(o_stop), 0);
    @(negedge clk);
    i_reset = 1'b1;
    for (int i = 0; i < 4; i++)
      cycle(ADD10, mke(1, 0, 10, 0, 0, 32'h5020, 0), $sformatf("mid.run%0d", i));

    // Debug mode: no step -> hold; one step -> one update.
    cycle(ADDI11, mke(1, 0, 0, 0, 0, 32'h7, 0), "dbg.pre");
    i_debug_mode = 1'b1;
    for (int i = 0; i < 5; i++)
      cycle(LW4, mke(1, 0, 0, 0, 0, 32'h7, 0), $sformatf("dbg.hold%0d", i));
    idle_inputs();
    i_instruction = LW4;
    i_step = 1'b1;
    sb_q.push_back(mke(1, 1, 0, 0, 0, 32'h4, 0));
    @(posedge clk); #1; pop_check("dbg.step");
    @(negedge clk);
    cycle(ADD10, mke(1, 1, 0, 0, 0, 32'h4, 0), "dbg.after");
    i_debug_mode = 1'b0;

    chk("scoreboard.drained", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
